// File: rtl/mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | mem_arbiter: one-at-a-time arbiter between fetch, LSB and memory ctrl.   |
// | Optional: ARB_STARVE_GUARD_EN lets a starved fetch beat a pending load.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int TYPE_WIDTH   = 7,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  ls_valid,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  input  logic [TYPE_WIDTH-1:0] ls_type,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mc_valid,
  output logic [ADDR_WIDTH-1:0] mc_addr,
  output logic [DATA_WIDTH-1:0] mc_wdata,
  output logic [TYPE_WIDTH-1:0] mc_type,
  output logic                  mc_is_fetch,
  input  logic                  mc_done,
  input  logic [DATA_WIDTH-1:0] mc_rdata
);

  localparam logic [TYPE_WIDTH-1:0] C_TYPE_SB = TYPE_WIDTH'(16);
  localparam logic [TYPE_WIDTH-1:0] C_TYPE_SH = TYPE_WIDTH'(17);
  localparam logic [TYPE_WIDTH-1:0] C_TYPE_SW = TYPE_WIDTH'(18);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_LS = 2'd1,
    S_BUSY_IF = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    mc_valid_q, mc_valid_d;
  logic [ADDR_WIDTH-1:0]   mc_addr_q, mc_addr_d;
  logic [DATA_WIDTH-1:0]   mc_wdata_q, mc_wdata_d;
  logic [TYPE_WIDTH-1:0]   mc_type_q, mc_type_d;
  logic                    mc_is_fetch_q, mc_is_fetch_d;
  logic                    if_done_q, if_done_d;
  logic [DATA_WIDTH-1:0]   if_data_q, if_data_d;
  logic                    ls_done_q, ls_done_d;
  logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;

  logic ls_store, ls_load, fetch_pri, take_ls, take_if, grant_ok;

  assign ls_store = ls_valid && (ls_type == C_TYPE_SB || ls_type == C_TYPE_SH ||
                                 ls_type == C_TYPE_SW);
  assign ls_load  = ls_valid && !ls_store;
  assign grant_ok = (state_q == S_IDLE) && !flush;
  assign take_ls  = ls_store || (ls_load && !fetch_pri);
  assign take_if  = !take_ls && if_valid;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q, starve_d;

  assign fetch_pri = if_valid && (starve_q >= C_LIMIT);

  // Saturates at the limit so a long run of stores cannot wrap it back to 0.
  always_comb begin
    starve_d = starve_q;
    if (!if_valid || (grant_ok && take_if)) begin
      starve_d = '0;
    end else if (grant_ok && take_ls && (starve_q < C_LIMIT)) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (rdy) begin
      starve_q <= starve_d;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign fetch_pri = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    mc_valid_d    = mc_valid_q;
    mc_addr_d     = mc_addr_q;
    mc_wdata_d    = mc_wdata_q;
    mc_type_d     = mc_type_q;
    mc_is_fetch_d = mc_is_fetch_q;
    if_done_d     = 1'b0;
    if_data_d     = if_data_q;
    ls_done_d     = 1'b0;
    ls_rdata_d    = ls_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (grant_ok && take_ls) begin
          state_d       = S_BUSY_LS;
          mc_valid_d    = 1'b1;
          mc_addr_d     = ls_addr;
          mc_wdata_d    = ls_wdata;
          mc_type_d     = ls_type;
          mc_is_fetch_d = 1'b0;
        end else if (grant_ok && take_if) begin
          state_d       = S_BUSY_IF;
          mc_valid_d    = 1'b1;
          mc_addr_d     = if_addr;
          mc_wdata_d    = '0;
          mc_type_d     = '0;
          mc_is_fetch_d = 1'b1;
        end
      end
      S_BUSY_LS: begin
        if (mc_done) begin
          state_d    = S_IDLE;
          mc_valid_d = 1'b0;
          ls_done_d  = 1'b1;
          ls_rdata_d = mc_rdata;
        end
      end
      S_BUSY_IF: begin
        // A flush coinciding with completion swallows the fetch result.
        if (mc_done) begin
          state_d    = S_IDLE;
          mc_valid_d = 1'b0;
          if (!flush) begin
            if_done_d = 1'b1;
            if_data_d = mc_rdata;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mc_done) begin
          state_d    = S_IDLE;
          mc_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mc_valid_q    <= 1'b0;
      mc_addr_q     <= '0;
      mc_wdata_q    <= '0;
      mc_type_q     <= '0;
      mc_is_fetch_q <= 1'b0;
      if_done_q     <= 1'b0;
      if_data_q     <= '0;
      ls_done_q     <= 1'b0;
      ls_rdata_q    <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      mc_valid_q    <= mc_valid_d;
      mc_addr_q     <= mc_addr_d;
      mc_wdata_q    <= mc_wdata_d;
      mc_type_q     <= mc_type_d;
      mc_is_fetch_q <= mc_is_fetch_d;
      if_done_q     <= if_done_d;
      if_data_q     <= if_data_d;
      ls_done_q     <= ls_done_d;
      ls_rdata_q    <= ls_rdata_d;
    end
  end

  assign mc_valid    = mc_valid_q;
  assign mc_addr     = mc_addr_q;
  assign mc_wdata    = mc_wdata_q;
  assign mc_type     = mc_type_q;
  assign mc_is_fetch = mc_is_fetch_q;
  assign if_done     = if_done_q;
  assign if_data     = if_data_q;
  assign ls_done     = ls_done_q;
  assign ls_rdata    = ls_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_arbiter;

  localparam logic [6:0] T_LH = 7'd12;
  localparam logic [6:0] T_LW = 7'd13;
  localparam logic [6:0] T_SB = 7'd16;
  localparam logic [6:0] T_SW = 7'd18;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_valid;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_valid;
  logic [31:0] ls_addr, ls_wdata;
  logic [6:0]  ls_type;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mc_valid;
  logic [31:0] mc_addr, mc_wdata;
  logic [6:0]  mc_type;
  logic        mc_is_fetch;
  logic        mc_done;
  logic [31:0] mc_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TYPE_WIDTH(7), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ls_valid(ls_valid), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_type(ls_type),
    .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_type(mc_type),
    .mc_is_fetch(mc_is_fetch), .mc_done(mc_done), .mc_rdata(mc_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic exp_fifth_fetch;

  initial begin
    // Reset with every requester active; the store must win first.
    rst = 1; rdy = 1; flush = 0; mc_done = 0; mc_rdata = 0;
    if_valid = 1; if_addr = 32'h0000_0040;
    ls_valid = 1; ls_addr = 32'h20; ls_wdata = 32'h1122_3344; ls_type = T_SW;
    tick(); tick();
    chk("rst_mc_valid", {31'b0, mc_valid}, 0);
    chk("rst_mc_addr", mc_addr, 0);
    chk("rst_mc_wdata", mc_wdata, 0);
    chk("rst_mc_type", {25'b0, mc_type}, 0);
    chk("rst_is_fetch", {31'b0, mc_is_fetch}, 0);
    chk("rst_if_done", {31'b0, if_done}, 0);
    chk("rst_ls_done", {31'b0, ls_done}, 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_ls_rdata", ls_rdata, 0);

    rst = 0;
    tick();
    chk("st_mc_valid", {31'b0, mc_valid}, 1);
    chk("st_mc_addr", mc_addr, 32'h20);
    chk("st_mc_wdata", mc_wdata, 32'h1122_3344);
    chk("st_mc_type", {25'b0, mc_type}, {25'b0, T_SW});
    chk("st_is_fetch", {31'b0, mc_is_fetch}, 0);
    tick(); tick();
    chk("st_no_if_done", {31'b0, if_done}, 0);
    chk("st_hold_addr", mc_addr, 32'h20);
    mc_done = 1;
    tick();
    chk("st_ls_done", {31'b0, ls_done}, 1);
    chk("st_if_quiet", {31'b0, if_done}, 0);
    chk("st_mc_clear", {31'b0, mc_valid}, 0);
    mc_done = 0; ls_valid = 0;
    tick();
    chk("st_ls_done_pulse", {31'b0, ls_done}, 0);
    chk("f1_is_fetch", {31'b0, mc_is_fetch}, 1);
    chk("f1_addr", mc_addr, 32'h40);
    chk("f1_type", {25'b0, mc_type}, 0);
    mc_done = 1; mc_rdata = 32'hCAFE_F00D;
    tick();
    chk("f1_if_done", {31'b0, if_done}, 1);
    chk("f1_if_data", if_data, 32'hCAFE_F00D);
    chk("f1_ls_quiet", {31'b0, ls_done}, 0);
    mc_done = 0; if_valid = 0;
    tick();
    chk("f1_if_done_pulse", {31'b0, if_done}, 0);
    chk("f1_idle", {31'b0, mc_valid}, 0);

    // Load versus fetch: load first, fetch once the load has finished.
    if_valid = 1; if_addr = 32'h2000;
    ls_valid = 1; ls_addr = 32'h1000; ls_type = T_LW; ls_wdata = 0;
    tick();
    chk("ld_addr", mc_addr, 32'h1000);
    chk("ld_is_fetch", {31'b0, mc_is_fetch}, 0);
    tick(); tick(); tick(); tick();
    mc_done = 1; mc_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ld_ls_done", {31'b0, ls_done}, 1);
    chk("ld_rdata", ls_rdata, 32'hDEAD_BEEF);
    chk("ld_idle_gap", {31'b0, mc_valid}, 0);
    mc_done = 0; ls_valid = 0;
    tick();
    chk("ld_then_fetch", {31'b0, mc_is_fetch}, 1);
    chk("ld_then_fetch_addr", mc_addr, 32'h2000);

    // Flush coincident with completion suppresses if_done.
    flush = 1; mc_done = 1; mc_rdata = 32'h5555_AAAA;
    tick();
    chk("fc_no_if_done", {31'b0, if_done}, 0);
    chk("fc_mc_clear", {31'b0, mc_valid}, 0);
    flush = 0; mc_done = 0; if_addr = 32'h400;
    tick();
    chk("fl_grant_addr", mc_addr, 32'h400);
    chk("fl_grant_fetch", {31'b0, mc_is_fetch}, 1);
    tick();
    flush = 1;
    tick();
    chk("fl_drain_valid", {31'b0, mc_valid}, 1);
    flush = 0; if_valid = 0;
    tick(); tick();
    chk("fl_drain_hold", {31'b0, mc_valid}, 1);
    chk("fl_drain_no_done", {31'b0, if_done}, 0);
    mc_done = 1;
    tick();
    chk("fl_drained", {31'b0, mc_valid}, 0);
    chk("fl_silent", {31'b0, if_done}, 0);
    mc_done = 0;
    tick();
    chk("fl_idle", {31'b0, mc_valid}, 0);

    // Stray completion while idle.
    mc_done = 1;
    tick();
    chk("idle_done_if", {31'b0, if_done}, 0);
    chk("idle_done_ls", {31'b0, ls_done}, 0);
    mc_done = 0;

    // Flush during an outstanding store has no effect.
    ls_valid = 1; ls_type = T_SB; ls_addr = 32'h30; ls_wdata = 32'hAB;
    tick();
    chk("fs_type", {25'b0, mc_type}, {25'b0, T_SB});
    flush = 1;
    tick();
    flush = 0;
    chk("fs_still_valid", {31'b0, mc_valid}, 1);
    mc_done = 1; mc_rdata = 0;
    tick();
    chk("fs_ls_done", {31'b0, ls_done}, 1);
    mc_done = 0; ls_valid = 0;
    tick();

    // rdy stall freezes state and outputs, including a done pulse.
    ls_valid = 1; ls_type = T_LH; ls_addr = 32'h44;
    tick();
    chk("rdy_grant", {31'b0, mc_valid}, 1);
    rdy = 0; ls_valid = 0; ls_addr = 32'h99;
    tick(); tick(); tick();
    chk("rdy_hold_valid", {31'b0, mc_valid}, 1);
    chk("rdy_hold_addr", mc_addr, 32'h44);
    rdy = 1; mc_done = 1; mc_rdata = 32'h0000_7777;
    tick();
    chk("rdy_ls_done", {31'b0, ls_done}, 1);
    rdy = 0; mc_done = 0;
    tick();
    chk("rdy_done_frozen", {31'b0, ls_done}, 1);
    chk("rdy_rdata_frozen", ls_rdata, 32'h0000_7777);
    rdy = 1;
    tick();
    chk("rdy_done_clear", {31'b0, ls_done}, 0);

    // Back-to-back loads with a waiting fetch.
    if_valid = 1; if_addr = 32'h800;
    ls_valid = 1; ls_type = T_LW; ls_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sv_load_grant", {31'b0, mc_is_fetch}, 0);
      mc_done = 1;
      tick();
      mc_done = 0;
    end
`ifdef ARB_STARVE_GUARD_EN
    exp_fifth_fetch = 1'b1;
`else
    exp_fifth_fetch = 1'b0;
`endif
    tick();
    chk("sv_fifth_grant", {31'b0, mc_is_fetch}, {31'b0, exp_fifth_fetch});
    chk("sv_fifth_valid", {31'b0, mc_valid}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
